// File: rtl/axi2mem_pkg.sv
// Shared encodings and types for the axi2mem bridge.
package axi2mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    RESP  = 2'd2
  } wr_state_t;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi2mem_burst_addr_gen.sv
// Combinational next-beat byte address for AXI bursts.
// Reserved encodings and illegal WRAP lengths step as INCR.
module axi2mem_burst_addr_gen
  import axi2mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [2:0]            i_size,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr
);

  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_mask;
  logic [ADDR_WIDTH-1:0] w_incr;
  logic                  w_wrap;

  assign w_step = ADDR_WIDTH'(1) << i_size;
  assign w_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size)
                  - ADDR_WIDTH'(1);
  assign w_incr = i_addr + w_step;
  assign w_wrap = (i_burst == BURST_WRAP) && wrap_len_ok(i_len);

  always_comb begin
    o_next_addr = w_incr;
    if (i_burst == BURST_FIXED) begin
      o_next_addr = i_addr;
    end else if (w_wrap) begin
      o_next_addr = (i_addr & ~w_mask) | (w_incr & w_mask);
    end
  end

endmodule

// File: rtl/axi2mem_wr_ctrl.sv
// AXI write-channel sequencer: one AW burst at a time,
// one memory write per W beat, one B per burst.
module axi2mem_wr_ctrl
  import axi2mem_pkg::*;
#(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    aw_valid_i,
  input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]              aw_len_i,
  input  logic [2:0]              aw_size_i,
  input  logic [1:0]              aw_burst_i,
  input  logic [ID_WIDTH-1:0]     aw_id_i,
  input  logic [USER_WIDTH-1:0]   aw_user_i,
  output logic                    aw_ready_o,
  input  logic                    w_valid_i,
  input  logic [DATA_WIDTH-1:0]   w_data_i,
  input  logic [DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                    w_last_i,
  output logic                    w_ready_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_add_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_gnt_i,
  output logic                    b_valid_o,
  output logic [1:0]              b_resp_o,
  output logic [ID_WIDTH-1:0]     b_id_o,
  output logic [USER_WIDTH-1:0]   b_user_o,
  input  logic                    b_ready_i
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH/8));

  wr_state_t             r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;
  logic [7:0]            r_cnt;
  logic                  r_err;
  logic [1:0]            r_resp;

  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_in_burst;
  logic                  w_fire;
  logic                  w_last_beat;
  logic                  w_last_mis;
  logic                  w_cfg_err;

  axi2mem_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .i_addr      (r_addr),
    .i_len       (r_len),
    .i_size      (r_size),
    .i_burst     (r_burst),
    .o_next_addr (w_next_addr)
  );

  assign w_in_burst  = (r_state == BURST);
  assign w_fire      = w_in_burst & w_valid_i & mem_gnt_i;
  assign w_last_beat = (r_cnt == r_len);
  assign w_last_mis  = (w_last_i != w_last_beat);
  assign w_cfg_err   = (r_burst == 2'b11) ||
                       ((r_burst == BURST_WRAP) && !wrap_len_ok(r_len)) ||
                       (r_size > SIZE_MAX);

  assign aw_ready_o  = (r_state == IDLE);
  assign mem_req_o   = w_in_burst & w_valid_i;
  assign w_ready_o   = w_in_burst & mem_gnt_i;
  assign mem_we_o    = mem_req_o;
  assign mem_add_o   = r_addr;
  assign mem_wdata_o = w_data_i;
  assign mem_be_o    = w_strb_i;
  assign b_valid_o   = (r_state == RESP);
  assign b_resp_o    = r_resp;
  assign b_id_o      = r_id;
  assign b_user_o    = r_user;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_id    <= '0;
      r_user  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_resp  <= RESP_OKAY;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (aw_valid_i) begin
            r_addr  <= aw_addr_i;
            r_len   <= aw_len_i;
            r_size  <= aw_size_i;
            r_burst <= aw_burst_i;
            r_id    <= aw_id_i;
            r_user  <= aw_user_i;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_fire) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= w_next_addr;
            if (w_last_mis) r_err <= 1'b1;
            // final beat's own mismatch must reach this response
            if (w_last_beat) begin
              r_resp  <= (r_err | w_last_mis | w_cfg_err) ?
                         RESP_SLVERR : RESP_OKAY;
              r_state <= RESP;
            end
          end
        end
        RESP: begin
          if (b_ready_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
